viterbi_ber_monitor: RTL

VITERBI_BER_MONITOR -- requirements
Module: viterbi_ber_monitor

---
 rtl/viterbi_ber_monitor.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/viterbi_ber_monitor.sv
// Bit-error-rate monitor for a Viterbi decoder: aligns decoded bits to a history
// of encoder input bits, locks on a run of matches, and counts errors per window.
module viterbi_ber_monitor #(
  parameter int DEPTH       = 64,
  parameter int SYNC_LEN    = 16,
  parameter int WINDOW      = 256,
  parameter int LOSS_THRESH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     tx_bit_i,
  input  logic                     tx_valid_i,
  input  logic                     rx_bit_i,
  input  logic                     rx_valid_i,
  input  logic                     clear_i,
  output logic                     locked_o,
  output logic [$clog2(DEPTH)-1:0] offset_o,
  output logic [31:0]              bit_cnt_o,
  output logic [31:0]              err_cnt_o,
  output logic [15:0]              win_err_o,
  output logic                     win_done_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int MW = $clog2(SYNC_LEN + 1);
  localparam int WW = $clog2(WINDOW + 1);
  localparam logic [AW:0] FILL_MAX = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    LOCKED = 2'd2
  } state_t;

  logic          hist_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW:0]   fill_cnt_r;

  state_t        state_r, state_s;
  logic [AW-1:0] offset_r, offset_s;
  logic [MW-1:0] match_r, match_s;
  logic [WW-1:0] win_cnt_r, win_cnt_s;
  logic [15:0]   win_acc_r, win_acc_s;
  logic [31:0]   bit_cnt_r, bit_cnt_s;
  logic [31:0]   err_cnt_r, err_cnt_s;
  logic [15:0]   win_err_r, win_err_s;
  logic          win_done_r, win_done_s;
  logic          locked_r;

  logic [AW-1:0] ref_idx_s;
  logic          ref_bit_s;
  logic          cmp_s;
  logic          miss_s;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    if (v == 32'hFFFF_FFFF) begin
      return v;
    end else begin
      return v + 32'd1;
    end
  endfunction

  // Offset 0 addresses the newest stored bit, read before this cycle's write lands.
  assign ref_idx_s = wr_ptr_r - AW'(1) - offset_r;
  assign ref_bit_s = hist_r[ref_idx_s];
  assign cmp_s     = rx_valid_i && (fill_cnt_r > {1'b0, offset_r});
  assign miss_s    = rx_bit_i ^ ref_bit_s;

  // History storage; contents are not reset and survive clear_i.
  always_ff @(posedge clk) begin
    if (tx_valid_i) begin
      hist_r[wr_ptr_r] <= tx_bit_i;
    end
  end

  // Write pointer and saturating fill level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_r   <= {AW{1'b0}};
      fill_cnt_r <= {(AW + 1){1'b0}};
    end else if (tx_valid_i) begin
      wr_ptr_r <= wr_ptr_r + AW'(1);
      if (fill_cnt_r != FILL_MAX) begin
        fill_cnt_r <= fill_cnt_r + (AW + 1)'(1);
      end
    end
  end

  // Alignment FSM, counters and window bookkeeping.
  always_comb begin
    state_s    = state_r;
    offset_s   = offset_r;
    match_s    = match_r;
    win_cnt_s  = win_cnt_r;
    win_acc_s  = win_acc_r;
    bit_cnt_s  = bit_cnt_r;
    err_cnt_s  = err_cnt_r;
    win_err_s  = win_err_r;
    win_done_s = 1'b0;
    if (clear_i) begin
      state_s   = IDLE;
      offset_s  = {AW{1'b0}};
      match_s   = {MW{1'b0}};
      win_cnt_s = {WW{1'b0}};
      win_acc_s = 16'd0;
      bit_cnt_s = 32'd0;
      err_cnt_s = 32'd0;
      win_err_s = 16'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (tx_valid_i) begin
            state_s  = SEARCH;
            offset_s = {AW{1'b0}};
            match_s  = {MW{1'b0}};
          end else begin
            state_s = IDLE;
          end
        end
        SEARCH: begin
          if (cmp_s && !miss_s) begin
            match_s = match_r + MW'(1);
            if (match_s == MW'(SYNC_LEN)) begin
              state_s   = LOCKED;
              match_s   = {MW{1'b0}};
              win_cnt_s = {WW{1'b0}};
              win_acc_s = 16'd0;
            end else begin
              state_s = SEARCH;
            end
          end else if (cmp_s) begin
            match_s  = {MW{1'b0}};
            offset_s = offset_r + AW'(1);
          end else begin
            state_s = SEARCH;
          end
        end
        LOCKED: begin
          if (cmp_s) begin
            bit_cnt_s = sat_inc32(bit_cnt_r);
            if (miss_s) begin
              err_cnt_s = sat_inc32(err_cnt_r);
              win_acc_s = win_acc_r + 16'd1;
            end else begin
              win_acc_s = win_acc_r;
            end
            win_cnt_s = win_cnt_r + WW'(1);
            // The closing compare is already folded into win_acc_s here.
            if (win_cnt_s == WW'(WINDOW)) begin
              win_err_s  = win_acc_s;
              win_done_s = 1'b1;
              win_cnt_s  = {WW{1'b0}};
              win_acc_s  = 16'd0;
              if (win_err_s > 16'(LOSS_THRESH)) begin
                state_s = SEARCH;
                match_s = {MW{1'b0}};
              end else begin
                state_s = LOCKED;
              end
            end else begin
              state_s = LOCKED;
            end
          end else begin
            state_s = LOCKED;
          end
        end
        default: begin
          state_s = IDLE;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= IDLE;
      offset_r   <= {AW{1'b0}};
      match_r    <= {MW{1'b0}};
      win_cnt_r  <= {WW{1'b0}};
      win_acc_r  <= 16'd0;
      bit_cnt_r  <= 32'd0;
      err_cnt_r  <= 32'd0;
      win_err_r  <= 16'd0;
      win_done_r <= 1'b0;
      locked_r   <= 1'b0;
    end else begin
      state_r    <= state_s;
      offset_r   <= offset_s;
      match_r    <= match_s;
      win_cnt_r  <= win_cnt_s;
      win_acc_r  <= win_acc_s;
      bit_cnt_r  <= bit_cnt_s;
      err_cnt_r  <= err_cnt_s;
      win_err_r  <= win_err_s;
      win_done_r <= win_done_s;
      locked_r   <= (state_s == LOCKED);
    end
  end

  assign locked_o   = locked_r;
  assign offset_o   = offset_r;
  assign bit_cnt_o  = bit_cnt_r;
  assign err_cnt_o  = err_cnt_r;
  assign win_err_o  = win_err_r;
  assign win_done_o = win_done_r;

endmodule
